rr_arb_4: RTL and testbench
===========================

Name: rr_arb_4

Overview:
- Four-requester round-robin arbiter with a registered output stage.
- Sits directly upstream of decoder_2_4. Its registered 2-bit grant index `out_idx` feeds that decoder, which produces one-hot bank/port enables.
- Arbitrates four valid/ready sources (e.g. LSU/IFU/PTW/debug) onto one shared downstream port.
- Supports multi-beat bursts: the grant is locked until the `last` beat of a burst is accepted.

Parameters:
DATA_W, 64, payload width per requester.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous active-high reset, sampled on rising clk.
req_valid  input  4  per-requester valid; bit i = requester i.
req_last  input  4  per-requester last-beat flag; qualified by req_valid[i].
req_data  input  4*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
req_ready  output  4  per-requester accept; at most one bit high per cycle.
out_valid  output  1  registered output holds a beat.
out_data  output  DATA_W  registered payload.
out_idx  output  2  registered index of the source of the current beat; drives decoder_2_4.in.
out_last  output  1  registered last flag of the current beat.
out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_idx=2'b00, out_last=0, ptr=2'b00, locked=0, lock_idx=2'b00. Any in-progress burst is dropped and the lock is cleared.
- can_load = ~out_valid | out_ready (combinational).
- Grant selection (combinational):
  - If locked: gnt = lock_idx, regardless of other requests.
  - Else: gnt = the first i with req_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - gnt_vld = locked ? req_valid[lock_idx] : |req_valid.
- req_ready[i] = can_load & gnt_vld & (gnt == i). A locked requester with req_valid low stalls the arbiter; there is no switch to another requester.
- Accept = can_load & gnt_vld. On the clk edge with accept:
  - out_valid<=1, out_data<=req_data[gnt], out_idx<=gnt, out_last<=req_last[gnt].
  - If req_last[gnt]=1: locked<=0 and ptr<=gnt+1 (2-bit wrap, so 3 -> 0).
  - Else: locked<=1, lock_idx<=gnt, ptr unchanged.
- On the clk edge with out_ready=1 and no accept: out_valid<=0.
- Latency: request to out_valid is 1 cycle.
- Throughput: 1 beat per cycle when out_ready is held high. A simultaneous drain and load on the same edge is allowed and produces no bubble.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable and req_ready=4'b0000.
- Single-beat requests: tie req_last high. The arbiter is then pure round-robin.
- Fairness: with all four requesting single beats continuously, the grant order is 0,1,2,3,0,... Each requester waits at most 3 beats plus its in-flight burst lengths.
- No combinational path from out_ready to out_data/out_idx. req_ready depends combinationally on out_ready.

Test Plan:
- Reset: rst high 2 cycles with all req_valid=4'b1111 -> out_valid=0, out_idx=0, req_ready=0 throughout; first grant after reset is requester 0.
- Round-robin: req_valid=4'b1111, req_last=4'b1111, out_ready=1 for 8 cycles -> out_idx sequence 0,1,2,3,0,1,2,3 on consecutive cycles, each req_ready bit one-hot.
- Pointer wrap and skip: ptr=3 with req_valid=4'b0101 -> grant 0, then 2, then 0; requester 3 never granted.
- Burst lock: req 1 sends a 3-beat burst (req_last=0,0,1) while req 0 and req 2 are valid -> out_idx=1 for 3 beats, then 2; req_ready[0] and req_ready[2] stay 0 during the burst.
- Backpressure: out_valid=1, out_data=0xA5, out_ready=0 for 4 cycles -> out_data/out_idx hold and req_ready=0; with out_ready=1 and a pending request, the next beat loads the same cycle with no bubble.
- Reset mid-burst: rst asserted after beat 2 of a locked burst from req 3 -> locked cleared, out_valid=0, next grant follows ptr=0 (requester 0 if valid).

Source files
------------

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with burst locking and a registered output beat.
// The grant index feeds a downstream 2-to-4 decoder through out_idx.
module rr_arb_4 #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req_valid,
    input  logic [3:0]          req_last,
    input  logic [4*DATA_W-1:0] req_data,
    output logic [3:0]          req_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_idx,
    output logic                out_last,
    input  logic                out_ready
);

    logic [1:0]        r_ptr;
    logic              r_locked;
    logic [1:0]        r_lock_idx;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_idx;
    logic              r_out_last;

    logic [DATA_W-1:0] w_data [4];
    logic [1:0]        w_scan_gnt;
    logic              w_scan_found;
    logic [1:0]        w_gnt;
    logic              w_gnt_vld;
    logic              w_can_load;
    logic              w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_data[gi]    = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = w_accept & (w_gnt == 2'(gi));
        end
    endgenerate

    // Scan starting at the pointer so the most recently finished requester goes last.
    always_comb begin
        logic [1:0] idx;
        w_scan_gnt   = r_ptr;
        w_scan_found = 1'b0;
        idx          = 2'b00;
        for (int k = 0; k < 4; k++) begin
            idx = r_ptr + 2'(k);
            if (!w_scan_found && req_valid[idx]) begin
                w_scan_gnt   = idx;
                w_scan_found = 1'b1;
            end
        end
    end

    assign w_gnt      = r_locked ? r_lock_idx : w_scan_gnt;
    assign w_gnt_vld  = r_locked ? req_valid[r_lock_idx] : (|req_valid);
    assign w_can_load = ~r_out_valid | out_ready;
    // Reset wins over any handshake, so no source sees an accept it would lose.
    assign w_accept   = w_can_load & w_gnt_vld & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= 2'b00;
            r_out_last  <= 1'b0;
            r_ptr       <= 2'b00;
            r_locked    <= 1'b0;
            r_lock_idx  <= 2'b00;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data[w_gnt];
            r_out_idx   <= w_gnt;
            r_out_last  <= req_last[w_gnt];
            if (req_last[w_gnt]) begin
                r_locked <= 1'b0;
                r_ptr    <= w_gnt + 2'd1;
            end else begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_gnt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_arb_4.sv
// Randomized and directed bench for rr_arb_4 against a distance-based round-robin model.
module tb_rr_arb_4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [63:0]  out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         out_ready;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Reference state
    int          m_ptr = 0;
    bit          m_locked = 0;
    int          m_lock = 0;
    bit          m_ov = 0;
    logic [63:0] m_od = '0;
    int          m_oi = 0;
    bit          m_ol = 0;

    rr_arb_4 #(.DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Grant = valid requester with the smallest forward distance from the pointer.
    function automatic int model_gnt(input logic [3:0] v);
        int best = -1;
        int bestd = 4;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && (((i - m_ptr) + 4) % 4) < bestd) begin
                bestd = ((i - m_ptr) + 4) % 4;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic ordy, input bit rnd_data);
        int  g;
        bit  gv;
        bit  acc;
        logic [3:0] exp_rdy;
        @(negedge clk);
        check("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        check("out_data", out_data, m_od);
        check("out_idx", {62'd0, out_idx}, 64'(m_oi));
        check("out_last", {63'd0, out_last}, {63'd0, m_ol});
        rst = r; req_valid = v; req_last = l; out_ready = ordy;
        if (rnd_data)
            for (int i = 0; i < 8; i++) req_data[i*32 +: 32] = $urandom;
        #1;
        if (m_locked) begin g = m_lock; gv = v[m_lock]; end
        else begin g = model_gnt(v); gv = (g >= 0); end
        acc = !r && (!m_ov || ordy) && gv;
        exp_rdy = acc ? (4'b0001 << g) : 4'b0000;
        check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        $display("cyc rst=%b v=%b l=%b ordy=%b rdy=%b exp=%b", r, v, l, ordy, req_ready, exp_rdy);
        @(posedge clk);
        if (r) begin
            m_ptr = 0; m_locked = 0; m_lock = 0; m_ov = 0; m_od = '0; m_oi = 0; m_ol = 0;
        end else if (acc) begin
            m_ov = 1; m_od = req_data[g*64 +: 64]; m_oi = g; m_ol = l[g];
            if (l[g]) begin m_locked = 0; m_ptr = (g + 1) % 4; end
            else begin m_locked = 1; m_lock = g; end
        end else if (ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic idx_is(input string tag, input int exp_idx);
        #1;
        check(tag, {62'd0, out_idx}, 64'(exp_idx));
        check({tag, "_v"}, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'hf; req_last = 4'hf; req_data = '0; out_ready = 1'b1;

        // Reset with everyone requesting
        cycle(1, 4'hf, 4'hf, 1, 1);
        cycle(1, 4'hf, 4'hf, 1, 1);
        cycle(0, 4'hf, 4'hf, 1, 1);
        idx_is("first_gnt", 0);

        // Pure round robin continues 1,2,3,0,1,2,3
        for (int k = 1; k < 8; k++) begin
            cycle(0, 4'hf, 4'hf, 1, 1);
            idx_is("rr_seq", k % 4);
        end

        // Drive ptr to 3, then 0101 must alternate 0,2,0
        cycle(0, 4'b0100, 4'hf, 1, 1);
        idx_is("ptr3_setup", 2);
        cycle(0, 4'b0101, 4'hf, 1, 1); idx_is("wrap0", 0);
        cycle(0, 4'b0101, 4'hf, 1, 1); idx_is("wrap2", 2);
        cycle(0, 4'b0101, 4'hf, 1, 1); idx_is("wrap0b", 0);

        // Three-beat burst from requester 1 while 0 and 2 compete
        cycle(0, 4'b0111, 4'b1101, 1, 1); idx_is("burst_b1", 1);
        cycle(0, 4'b0111, 4'b1101, 1, 1); idx_is("burst_b2", 1);
        cycle(0, 4'b0111, 4'b1111, 1, 1); idx_is("burst_b3", 1);
        cycle(0, 4'b0111, 4'b1111, 1, 1); idx_is("burst_after", 2);

        // Backpressure hold on an 0xA5 beat, then load without bubble
        req_data[63:0] = 64'hA5;
        cycle(0, 4'b0001, 4'hf, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 4'b0001, 4'hf, 0, 1);
            #1 check("bp_hold_data", out_data, 64'hA5);
        end
        cycle(0, 4'b0010, 4'hf, 1, 1); idx_is("bp_release", 1);

        // Reset in the middle of a requester-3 burst
        cycle(0, 4'b1000, 4'b0000, 1, 1); idx_is("rb_b1", 3);
        cycle(0, 4'b1000, 4'b0000, 1, 1); idx_is("rb_b2", 3);
        cycle(1, 4'b1000, 4'b0000, 1, 1);
        #1 check("rb_valid_low", {63'd0, out_valid}, 64'd0);
        cycle(0, 4'hf, 4'hf, 1, 1); idx_is("rb_regrant", 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom | $urandom),
                  ($urandom_range(0, 3) != 0), 1);
        end
        cycle(0, 4'h0, 4'h0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
